// File: rtl/pcie_phy_pkg.sv
// Shared definitions for the PCIe PHY transmit path: symbol width, the COM
// idle symbol, and the serializer TX state encoding.
package pcie_phy_pkg;

  localparam int                   SYM_WIDTH = 8;
  localparam logic [SYM_WIDTH-1:0] COM_SYM   = 8'hBC;

  typedef enum logic {
    IDLE_TX = 1'b0,
    DATA_TX = 1'b1
  } tx_state_e;

endpackage

// File: rtl/phy_byte_fifo.sv
// Small synchronous FIFO buffering mux output bytes ahead of the serializer.
// Read data is the head entry, presented combinationally; a pop advances it.
module phy_byte_fifo
  import pcie_phy_pkg::*;
#(
  parameter int WIDTH = SYM_WIDTH,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int             PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int             CW      = PW + 1;
  localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_wr, do_rd;

  assign full    = (cnt_q == DEPTH_C);
  assign empty   = (cnt_q == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem_q[rd_ptr_q];

  // Pointer and occupancy next-state; pointers wrap naturally (DEPTH is 2^n).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_wr, do_rd})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state register; reset flushes the FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage array; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/par_to_serial.sv
// Byte-to-bit serializer for the PHY TX lane. Bytes from the mux are queued
// in a small FIFO; every WIDTH clocks a new symbol is loaded, either the FIFO
// head or the COM idle symbol, so the serial stream never stalls.
module par_to_serial
  import pcie_phy_pkg::*;
#(
  parameter int               WIDTH     = SYM_WIDTH,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] IDLE_SYM  = WIDTH'(COM_SYM),
  parameter bit               MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready,
  output logic             data_out,
  output logic             byte_start,
  output logic             is_data,
  output logic             err_overflow
);

  localparam int              CNTW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(WIDTH - 1);

  tx_state_e        state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic             bstart_q, bstart_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] fifo_rd_data;
  logic             fifo_full, fifo_empty;
  logic             wr_en, rd_en, load;

  // A load edge is the last bit slot of the current symbol.
  assign load  = (cnt_q == LAST_CNT);
  assign ready = !fifo_full && !reset;
  assign wr_en = valid_in && ready;
  assign rd_en = load && !fifo_empty && !reset;

  phy_byte_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (data_in),
    .rd_en   (rd_en),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Next-state: counter wrap, symbol load or shift, TX state and sticky error.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bstart_d = 1'b0;
    cnt_d    = load ? '0 : cnt_q + 1'b1;
    err_d    = err_q | (valid_in && !ready && !reset);
    if (load) begin
      bstart_d = 1'b1;
      if (!fifo_empty) begin
        state_d = DATA_TX;
        shift_d = fifo_rd_data;
      end else begin
        state_d = IDLE_TX;
        shift_d = IDLE_SYM;
      end
    end else if (MSB_FIRST) begin
      shift_d = {shift_q[WIDTH-2:0], 1'b0};
    end else begin
      shift_d = {1'b0, shift_q[WIDTH-1:1]};
    end
  end

  // State register; reset aborts any partial symbol and arms a load next edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE_TX;
      shift_q  <= '0;
      cnt_q    <= LAST_CNT;
      bstart_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      bstart_q <= bstart_d;
      err_q    <= err_d;
    end
  end

  assign data_out     = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];
  assign byte_start   = bstart_q;
  assign is_data      = (state_q == DATA_TX);
  assign err_overflow = err_q;

endmodule

// File: tb/tb_par_to_serial.sv
// Bench for par_to_serial: an MSB-first and an LSB-first instance share the
// same stimulus; a queue-based stream model predicts every output each cycle.
module tb_par_to_serial;

  localparam int D = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       valid_in;
  logic [7:0] data_in;

  logic ready_m, dout_m, bs_m, isd_m, err_m;
  logic ready_l, dout_l, bs_l, isd_l, err_l;

  par_to_serial #(.WIDTH(8), .DEPTH(D), .IDLE_SYM(8'hBC), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .ready(ready_m), .data_out(dout_m), .byte_start(bs_m),
    .is_data(isd_m), .err_overflow(err_m)
  );

  par_to_serial #(.WIDTH(8), .DEPTH(D), .IDLE_SYM(8'hBC), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .ready(ready_l), .data_out(dout_l), .byte_start(bs_l),
    .is_data(isd_l), .err_overflow(err_l)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Stream model: queued bytes, symbol on the wire, bit index within it,
  // and the slot phase (0 means the next edge starts a new symbol).
  logic [7:0] mq[$];
  logic [7:0] m_sym = 8'h00;
  int         m_bit = 0;
  int         m_ph  = 0;
  bit         m_isd = 0;
  bit         m_bs  = 0;
  bit         m_err = 0;

  logic [7:0] col_m, col_l;
  bit         col_bs0;
  int         col_isd;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit was_full;
    if (reset) begin
      mq.delete();
      m_sym = 8'h00; m_bit = 0; m_ph = 0;
      m_isd = 0; m_bs = 0; m_err = 0;
    end else begin
      was_full = (mq.size() >= D);
      if (valid_in && was_full) m_err = 1;
      if (m_ph == 0) begin
        if (mq.size() > 0) begin
          m_sym = mq.pop_front();
          m_isd = 1;
        end else begin
          m_sym = 8'hBC;
          m_isd = 0;
        end
        m_bit = 0;
        m_bs  = 1;
      end else begin
        m_bit++;
        m_bs = 0;
      end
      if (valid_in && !was_full) mq.push_back(data_in);
      m_ph = (m_ph + 1) % 8;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("dout_msb", dout_m, m_sym[7 - m_bit]);
    chk("dout_lsb", dout_l, m_sym[m_bit]);
    chk("byte_start", bs_m, m_bs);
    chk("byte_start_l", bs_l, m_bs);
    chk("is_data", isd_m, m_isd);
    chk("is_data_l", isd_l, m_isd);
    chk("ready", ready_m, !reset && (mq.size() < D));
    chk("ready_l", ready_l, !reset && (mq.size() < D));
    chk("err", err_m, m_err);
    chk("err_l", err_l, m_err);
  endtask

  // Eight cycles of output, first-transmitted bit ends up in bit 7.
  task automatic collect();
    col_isd = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      col_m = {col_m[6:0], dout_m};
      col_l = {col_l[6:0], dout_l};
      if (i == 0) col_bs0 = bs_m;
      if (isd_m === 1'b1) col_isd++;
    end
  endtask

  task automatic align();
    while (m_ph != 0) tick();
  endtask

  initial begin
    // reset held with valid high
    reset = 1'b1; valid_in = 1'b1; data_in = 8'h55;
    repeat (3) tick();
    chk("rst_dout", dout_m, 1'b0);
    chk("rst_ready", ready_m, 1'b0);
    chk("rst_err", err_m, 1'b0);

    // idle stream
    reset = 1'b0; valid_in = 1'b0;
    collect();
    chk("idle_sym", col_m, 8'hBC);
    chk("idle_bs0", col_bs0, 1'b1);
    chk("idle_isd", col_isd, 0);
    collect();
    chk("idle_sym2", col_m, 8'hBC);

    // single byte written during bit 3 of an idle symbol
    repeat (3) tick();
    valid_in = 1'b1; data_in = 8'hA5;
    tick();
    valid_in = 1'b0;
    align();
    collect();
    chk("single_byte", col_m, 8'hA5);
    chk("single_isd", col_isd, 8);
    collect();
    chk("single_after", col_m, 8'hBC);

    // overflow
    tick();
    valid_in = 1'b1; data_in = 8'h01; tick();
    data_in = 8'h02; tick();
    chk("ovf_ready", ready_m, 1'b0);
    data_in = 8'h03; tick();
    valid_in = 1'b0;
    chk("ovf_err", err_m, 1'b1);
    align();
    collect(); chk("ovf_b1", col_m, 8'h01);
    collect(); chk("ovf_b2", col_m, 8'h02);
    collect(); chk("ovf_b3", col_m, 8'hBC);
    chk("ovf_sticky", err_m, 1'b1);

    // reset mid-symbol with a byte still queued
    tick();
    valid_in = 1'b1; data_in = 8'hA5; tick();
    valid_in = 1'b0;
    align();
    tick();
    valid_in = 1'b1; data_in = 8'h3C; tick();
    valid_in = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    chk("midrst_dout", dout_m, 1'b0);
    chk("midrst_err", err_m, 1'b0);
    reset = 1'b0;
    collect();
    chk("midrst_sym", col_m, 8'hBC);
    chk("midrst_bs0", col_bs0, 1'b1);
    chk("midrst_isd", col_isd, 0);

    // bit order
    tick();
    valid_in = 1'b1; data_in = 8'h0F; tick();
    valid_in = 1'b0;
    align();
    collect();
    chk("order_msb", col_m, 8'h0F);
    chk("order_lsb", col_l, 8'hF0);

    // randomized traffic with occasional resets
    for (int n = 0; n < 800; n++) begin
      reset    = ($urandom_range(0, 79) == 0);
      valid_in = ($urandom_range(0, 9) < 3);
      data_in  = 8'($urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
